// File: rtl/hdmi_video_timing.sv
// hdmi_video_timing: CEA-861 raster generator for the HDMI transmitter.
// Emits position, syncs, DE, video preamble/guard band and a lead fetch stream.
module hdmi_video_timing #(
  parameter int H_ACTIVE   = 720,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 62,
  parameter int H_BACK     = 60,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 9,
  parameter int V_SYNC     = 6,
  parameter int V_BACK     = 30,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int FETCH_LEAD = 2,
  parameter int CW         = 12
) (
  input  logic          pixelClock,
  input  logic          reset,
  input  logic          enable,
  output logic [CW-1:0] hPos,
  output logic [CW-1:0] vPos,
  output logic          hSync,
  output logic          vSync,
  output logic          DE,
  output logic          fetchRequest,
  output logic [CW-1:0] fetchX,
  output logic [CW-1:0] fetchY,
  output logic          videoPreamble,
  output logic          videoGuardBand,
  output logic [3:0]    ctl,
  output logic          lineStart,
  output logic          frameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HA     = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VA     = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS0    = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS1    = CW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS0    = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS1    = CW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [CW-1:0] PRE0   = CW'(H_TOTAL - 10);
  localparam logic [CW-1:0] PRE1   = CW'(H_TOTAL - 3);
  localparam logic [CW-1:0] GB0    = CW'(H_TOTAL - 2);
  localparam logic [CW-1:0] LEAD0  = CW'(FETCH_LEAD % H_TOTAL);
  localparam logic          HS_OFF = (H_SYNC_POL == 0) ? 1'b1 : 1'b0;
  localparam logic          VS_OFF = (V_SYNC_POL == 0) ? 1'b1 : 1'b0;
  localparam logic          FR0    = (LEAD0 < HA) ? 1'b1 : 1'b0;

  function automatic logic [CW-1:0] step(
    input logic [CW-1:0] c,
    input logic [CW-1:0] last
  );
    return (c == last) ? '0 : c + 1'b1;
  endfunction

  logic [CW-1:0] hPos_q, hPos_d;
  logic [CW-1:0] vPos_q, vPos_d;
  logic [CW-1:0] fx_q, fx_d;
  logic [CW-1:0] fy_q, fy_d;
  logic [CW-1:0] nl_d;
  logic de_q, de_d;
  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic pre_q, pre_d;
  logic gb_q, gb_d;
  logic fr_q, fr_d;

  // Advance both counters one pixel and decode the outputs at the new position.
  always_comb begin
    hPos_d = step(hPos_q, H_LAST);
    vPos_d = vPos_q;
    if (hPos_q == H_LAST) vPos_d = step(vPos_q, V_LAST);
    fx_d = step(fx_q, H_LAST);
    fy_d = fy_q;
    if (fx_q == H_LAST) fy_d = step(fy_q, V_LAST);
    nl_d  = step(vPos_d, V_LAST);
    de_d  = (hPos_d < HA) && (vPos_d < VA);
    hs_d  = ((hPos_d >= HS0) && (hPos_d <= HS1)) ^ HS_OFF;
    vs_d  = ((vPos_d >= VS0) && (vPos_d <= VS1)) ^ VS_OFF;
    pre_d = (nl_d < VA) && (hPos_d >= PRE0) && (hPos_d <= PRE1);
    gb_d  = (nl_d < VA) && (hPos_d >= GB0);
    fr_d  = (fx_d < HA) && (fy_d < VA);
  end

  // Position and decoded-output registers; reset wins over enable.
  always_ff @(posedge pixelClock) begin
    if (reset) begin
      hPos_q <= '0;
      vPos_q <= '0;
      fx_q   <= LEAD0;
      fy_q   <= '0;
      de_q   <= 1'b1;
      hs_q   <= HS_OFF;
      vs_q   <= VS_OFF;
      pre_q  <= 1'b0;
      gb_q   <= 1'b0;
      fr_q   <= FR0;
    end else if (enable) begin
      hPos_q <= hPos_d;
      vPos_q <= vPos_d;
      fx_q   <= fx_d;
      fy_q   <= fy_d;
      de_q   <= de_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      pre_q  <= pre_d;
      gb_q   <= gb_d;
      fr_q   <= fr_d;
    end
  end

  assign hPos           = hPos_q;
  assign vPos           = vPos_q;
  assign hSync          = hs_q;
  assign vSync          = vs_q;
  assign DE             = de_q;
  assign fetchRequest   = fr_q;
  assign fetchX         = fx_q;
  assign fetchY         = fy_q;
  assign videoPreamble  = pre_q;
  assign videoGuardBand = gb_q;
  assign ctl            = {3'b000, pre_q};
  assign lineStart      = enable && (hPos_q == '0);
  assign frameStart     = lineStart && (vPos_q == '0);

endmodule

// File: tb/tb_hdmi_video_timing.sv
// tb_hdmi_video_timing: small-raster bench for hdmi_video_timing.
// Hand vectors, corner sequences and a queue-based reference model.
module tb_hdmi_video_timing;

  localparam int HA = 4, HF = 1, HS = 2, HB = 10;
  localparam int VA = 2, VF = 1, VS = 1, VB = 1;
  localparam int LEAD = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;

  logic        pixelClock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] hPos, vPos, fetchX, fetchY;
  logic        hSync, vSync, DE, fetchRequest;
  logic        videoPreamble, videoGuardBand;
  logic [3:0]  ctl;
  logic        lineStart, frameStart;

  hdmi_video_timing #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(1), .V_SYNC_POL(0), .FETCH_LEAD(LEAD), .CW(12)
  ) dut (
    .pixelClock(pixelClock), .reset(reset), .enable(enable),
    .hPos(hPos), .vPos(vPos), .hSync(hSync), .vSync(vSync), .DE(DE),
    .fetchRequest(fetchRequest), .fetchX(fetchX), .fetchY(fetchY),
    .videoPreamble(videoPreamble), .videoGuardBand(videoGuardBand),
    .ctl(ctl), .lineStart(lineStart), .frameStart(frameStart)
  );

  always #5 pixelClock = ~pixelClock;

  typedef struct {
    int h, v, de, hs, vs, pre, gb, fr, fx, fy;
  } exp_t;

  typedef struct {
    int   n;
    exp_t e;
  } vec_t;

  int   n_pass = 0;
  int   n_tot  = 0;
  int   n_en   = 0;
  exp_t sb[$];

  task automatic check(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  function automatic exp_t model(input int n);
    exp_t e;
    int p, q, nl;
    p = n % FR;
    q = (n + LEAD) % FR;
    e.h  = p % HT;
    e.v  = p / HT;
    e.de = (e.h < HA && e.v < VA) ? 1 : 0;
    e.hs = (e.h >= HA + HF && e.h < HA + HF + HS) ? 1 : 0;
    e.vs = (e.v >= VA + VF && e.v < VA + VF + VS) ? 0 : 1;
    nl   = (e.v == VT - 1) ? 0 : e.v + 1;
    e.pre = (nl < VA && e.h >= HT - 10 && e.h <= HT - 3) ? 1 : 0;
    e.gb  = (nl < VA && e.h >= HT - 2) ? 1 : 0;
    e.fx = q % HT;
    e.fy = q / HT;
    e.fr = (e.fx < HA && e.fy < VA) ? 1 : 0;
    return e;
  endfunction

  task automatic cmp_all(input string t, input exp_t e);
    check({t, ".hPos"}, int'(hPos), e.h);
    check({t, ".vPos"}, int'(vPos), e.v);
    check({t, ".DE"}, int'(DE), e.de);
    check({t, ".hSync"}, int'(hSync), e.hs);
    check({t, ".vSync"}, int'(vSync), e.vs);
    check({t, ".pre"}, int'(videoPreamble), e.pre);
    check({t, ".gb"}, int'(videoGuardBand), e.gb);
    check({t, ".ctl"}, int'(ctl), e.pre);
    check({t, ".fetchReq"}, int'(fetchRequest), e.fr);
    check({t, ".fetchX"}, int'(fetchX), e.fx);
    check({t, ".fetchY"}, int'(fetchY), e.fy);
  endtask

  task automatic tick(input logic r, input logic en);
    reset  = r;
    enable = en;
    @(negedge pixelClock);
  endtask

  vec_t vt[$];

  function automatic exp_t mk(input int h, v, de, hs, vs,
                              pre, gb, fr, fx, fy);
    exp_t e;
    e.h = h; e.v = v; e.de = de; e.hs = hs; e.vs = vs;
    e.pre = pre; e.gb = gb; e.fr = fr; e.fx = fx; e.fy = fy;
    return e;
  endfunction

  initial begin
    int first, second, hsc, hs_at;
    exp_t cur;
    logic en;

    //            h  v de hs vs pr gb fr fx fy
    vt.push_back('{0,  mk(0, 0, 1, 0, 1, 0, 0, 1, 3, 0)});
    vt.push_back('{1,  mk(1, 0, 1, 0, 1, 0, 0, 0, 4, 0)});
    vt.push_back('{3,  mk(3, 0, 1, 0, 1, 0, 0, 0, 6, 0)});
    vt.push_back('{4,  mk(4, 0, 0, 0, 1, 0, 0, 0, 7, 0)});
    vt.push_back('{5,  mk(5, 0, 0, 1, 1, 0, 0, 0, 8, 0)});
    vt.push_back('{6,  mk(6, 0, 0, 1, 1, 0, 0, 0, 9, 0)});
    vt.push_back('{7,  mk(7, 0, 0, 0, 1, 1, 0, 0, 10, 0)});
    vt.push_back('{14, mk(14, 0, 0, 0, 1, 1, 0, 1, 0, 1)});
    vt.push_back('{15, mk(15, 0, 0, 0, 1, 0, 1, 1, 1, 1)});
    vt.push_back('{16, mk(16, 0, 0, 0, 1, 0, 1, 1, 2, 1)});
    vt.push_back('{17, mk(0, 1, 1, 0, 1, 0, 0, 1, 3, 1)});
    vt.push_back('{24, mk(7, 1, 0, 0, 1, 0, 0, 0, 10, 1)});
    vt.push_back('{34, mk(0, 2, 0, 0, 1, 0, 0, 0, 3, 2)});
    vt.push_back('{51, mk(0, 3, 0, 0, 0, 0, 0, 0, 3, 3)});
    vt.push_back('{68, mk(0, 4, 0, 0, 1, 0, 0, 0, 3, 4)});
    vt.push_back('{75, mk(7, 4, 0, 0, 1, 1, 0, 0, 10, 4)});
    vt.push_back('{82, mk(14, 4, 0, 0, 1, 1, 0, 1, 0, 0)});
    vt.push_back('{83, mk(15, 4, 0, 0, 1, 0, 1, 1, 1, 0)});
    vt.push_back('{84, mk(16, 4, 0, 0, 1, 0, 1, 1, 2, 0)});
    vt.push_back('{85, mk(0, 0, 1, 0, 1, 0, 0, 1, 3, 0)});

    @(negedge pixelClock);
    tick(1'b1, 1'b0);
    cmp_all("rst", vt[0].e);

    foreach (vt[i]) begin
      tick(1'b1, 1'b1);
      repeat (vt[i].n) tick(1'b0, 1'b1);
      enable = 1'b0;
      cmp_all($sformatf("vec%0d", vt[i].n), vt[i].e);
    end

    tick(1'b1, 1'b0);
    reset = 1'b0;
    enable = 1'b1;
    first = -1; second = -1; hsc = 0; hs_at = -1;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (c < HT && hSync) begin
        hsc++;
        if (hs_at < 0) hs_at = c;
      end
      if (frameStart) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      if (second >= 0) break;
      @(negedge pixelClock);
    end
    check("frame_period", second - first, FR);
    check("hsync_width", hsc, HS);
    check("hsync_start", hs_at, HA + HF);

    tick(1'b1, 1'b1);
    repeat (40) tick(1'b0, 1'b1);
    cmp_all("pre_rst", model(40));
    tick(1'b1, 1'b0);
    cmp_all("mid_rst", model(0));
    tick(1'b0, 1'b0);
    cmp_all("rst_hold", model(0));
    #1;
    check("ls_off", int'(lineStart), 0);
    check("fs_off", int'(frameStart), 0);
    tick(1'b0, 1'b1);
    cmp_all("restart", model(1));

    tick(1'b1, 1'b1);
    repeat (84) tick(1'b0, 1'b1);
    cmp_all("last", model(84));
    #1;
    check("fs_last", int'(frameStart), 0);
    check("ls_last", int'(lineStart), 0);
    tick(1'b0, 1'b1);
    #1;
    check("wrap_h", int'(hPos), 0);
    check("wrap_v", int'(vPos), 0);
    check("wrap_de", int'(DE), 1);
    check("wrap_fs", int'(frameStart), 1);
    check("wrap_ls", int'(lineStart), 1);
    enable = 1'b0;
    #1;
    check("wrap_fs_dis", int'(frameStart), 0);

    tick(1'b1, 1'b0);
    n_en = 0;
    for (int c = 0; c < 400; c++) begin
      if (sb.size() > 0) cmp_all($sformatf("rnd%0d", c), sb.pop_front());
      en = 1'($urandom_range(0, 1));
      reset = 1'b0;
      enable = en;
      #1;
      cur = model(n_en);
      check("rnd_ls", int'(lineStart), (en && cur.h == 0) ? 1 : 0);
      check("rnd_fs", int'(frameStart),
            (en && cur.h == 0 && cur.v == 0) ? 1 : 0);
      if (en) n_en++;
      sb.push_back(model(n_en));
      @(negedge pixelClock);
    end
    while (sb.size() > 0) cmp_all("rnd_end", sb.pop_front());

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/hdmi_video_timing.md
# hdmi_video_timing

Parametrised video timing generator for the HDMI transmitter. It produces the pixel position, sync, data-enable and HDMI video-period control signals that feed the TMDS encoder/serializer channels. It also produces an early pixel-fetch request so an upstream pixel source can deliver RGB data in step with DE. All CEA-861 timings are generic parameters; the defaults give 720x480p60 (858x525 total).

## Interface
- H_ACTIVE, 720, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 62, hSync width (pixels)
- H_BACK, 60, horizontal back porch (pixels); must be >= 10
- V_ACTIVE, 480, active lines
- V_FRONT, 9, vertical front porch (lines)
- V_SYNC, 6, vSync width (lines)
- V_BACK, 30, vertical back porch (lines)
- H_SYNC_POL, 0, 1 = hSync active-high, 0 = active-low
- V_SYNC_POL, 0, 1 = vSync active-high, 0 = active-low
- FETCH_LEAD, 2, cycles by which fetchRequest leads DE; range 0..H_BACK-1
- CW, 12, counter width; must satisfy 2^CW > max(H_TOTAL, V_TOTAL)

Ports:
- pixelClock  in  1  pixel clock
- reset  in  1  synchronous, active-high
- enable  in  1  pixel advance strobe; when low, all state holds
- hPos  out  CW  current horizontal position, 0..H_TOTAL-1
- vPos  out  CW  current line, 0..V_TOTAL-1
- hSync  out  1  horizontal sync, at the configured polarity
- vSync  out  1  vertical sync, at the configured polarity
- DE  out  1  active video
- fetchRequest  out  1  pixel (fetchX, fetchY) is displayed FETCH_LEAD enabled cycles later
- fetchX  out  CW  fetch column
- fetchY  out  CW  fetch line
- videoPreamble  out  1  HDMI video preamble period
- videoGuardBand  out  1  HDMI video leading guard band period
- ctl  out  4  {CTL3..CTL0}; drives the green/red encoder control buses
- lineStart  out  1  high when hPos==0 && enable
- frameStart  out  1  high when hPos==0 && vPos==0 && enable

## Operation
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK.
- V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK.
- Position counter:
  - On each enabled cycle, hPos increments.
  - At H_TOTAL-1, hPos wraps to 0 and vPos increments.
  - When vPos is at V_TOTAL-1 as hPos wraps, vPos also wraps to 0.
  - No terminal-value overshoot: counters never reach H_TOTAL or V_TOTAL.
- All decoded outputs are functions of the current (hPos, vPos) and are aligned with them in the same cycle. They are registered: next values are computed from the next position.
- DE = hPos<H_ACTIVE && vPos<V_ACTIVE.
- hSync is logically active for hPos in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1]. The output is the logical value XOR !H_SYNC_POL.
- vSync is logically active for vPos in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1], over whole lines. Transitions occur at hPos==0. The output uses V_SYNC_POL in the same way.
- Define nextLine = (vPos==V_TOTAL-1) ? 0 : vPos+1. The line is "pre-active" when nextLine<V_ACTIVE.
- videoPreamble = pre-active && hPos in [H_TOTAL-10, H_TOTAL-3], which is 8 cycles.
- videoGuardBand = pre-active && hPos in [H_TOTAL-2, H_TOTAL-1], which is 2 cycles.
- ctl = 4'b0001 during videoPreamble, otherwise 4'b0000.
- Fetch path:
  - A second position counter runs FETCH_LEAD enabled cycles ahead of (hPos, vPos), wrapping identically.
  - fetchX and fetchY are its coordinates.
  - fetchRequest is the DE decode of that lead position.
  - With FETCH_LEAD=0, fetchRequest==DE and fetch coordinates equal hPos/vPos.

## Timing
- Reset values:
  - hPos=0, vPos=0, DE=1.
  - hSync = !H_SYNC_POL and vSync = !V_SYNC_POL (both inactive).
  - videoPreamble=0, videoGuardBand=0, ctl=0.
  - Lead counter: (FETCH_LEAD mod H_TOTAL, 0). fetchRequest = (FETCH_LEAD<H_ACTIVE).
- The first enabled cycle after reset release is pixel (0,0).
- Reset mid-frame returns all outputs to their reset values on the next clock edge, regardless of enable.
- enable=0:
  - hPos, vPos, the lead counter and all registered outputs hold.
  - lineStart and frameStart are 0.
  - Counting resumes from the held position.
- lineStart and frameStart are combinational from enable and the position registers. They are single-cycle per enabled cycle.
- Frame period is H_TOTAL*V_TOTAL enabled cycles. Line period is H_TOTAL enabled cycles.
- With a continuous enable, the guard band is immediately followed by the first DE cycle of the line.

## Test plan
- Defaults, continuous enable, active-low syncs:
  - hSync is 0 exactly for hPos 736..797.
  - vSync is 0 exactly for lines 489..494.
  - Consecutive frameStart pulses are 450450 cycles apart.
- Defaults, preamble and guard band:
  - Preamble (ctl=0001) occurs at hPos 848..855, followed by guard band at 856..857.
  - It appears on line 524 and on lines 0..478.
  - It does not appear on lines 479..523.
- Small configuration (H 4/1/2/10, V 2/1/1/1, FETCH_LEAD=3, H_SYNC_POL=1):
  - H_TOTAL=17 and V_TOTAL=5.
  - hSync is 1 for hPos 5..6.
  - fetchRequest rises 3 cycles before DE with fetchX=0.
  - The fetch coordinate stream equals the DE pixel stream delayed by 3.
- Randomised enable (about 50% duty):
  - Positions and outputs hold while enable is low.
  - The sequence of (hPos, vPos, DE, hSync, vSync) sampled on enabled cycles matches the continuous-enable sequence.
- Reset asserted at (hPos=300, vPos=200) for 1 cycle:
  - The next cycle shows all reset values.
  - Counting restarts from (0,0).
  - Reset is honoured while enable=0.
- Wrap boundary:
  - At (H_TOTAL-1, V_TOTAL-1), the next enabled cycle gives (0,0).
  - frameStart=1 and DE=1 in that cycle.
  - hPos and vPos never equal H_TOTAL or V_TOTAL.
